// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The optional parity bit is selected with the macro UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 5208;
  localparam int unsigned FRAME_BITS_NOPAR = 10;
  localparam int unsigned FRAME_BITS_PAR   = 11;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last count of each bit; held at 0 while disabled.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = 16'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = 16'd0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 frame).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       btn0,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       onebit_data,
  output logic       busy,
  output logic       last_grant
);

  // Handshake: reqN is held high until the single-cycle gntN pulse; dataN is
  // captured on the clock edge that ends the gntN cycle, so it may change after.

  uart_state_e state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        last_grant_q, last_grant_d;
  logic        tick;
  logic        gnt0_c, gnt1_c;
  logic        tx_bit;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (btn0),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    bit_idx_d    = bit_idx_q;
    last_grant_d = last_grant_q;
    gnt0_c       = 1'b0;
    gnt1_c       = 1'b0;
    tx_bit       = 1'b1;
    case (state_q)
      IDLE: begin
        // Under contention the requester that was not granted last wins.
        if (req0 && (!req1 || last_grant_q)) begin
          gnt0_c       = 1'b1;
          data_d       = data0;
          last_grant_d = 1'b0;
          state_d      = START;
        end else if (req1) begin
          gnt1_c       = 1'b1;
          data_d       = data1;
          last_grant_d = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (tick) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_bit = data_q[bit_idx_q];
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        tx_bit = even_parity(data_q);
        if (tick) begin
          state_d = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        tx_bit = 1'b1;
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge btn0) begin
    if (btn0) begin
      state_q      <= IDLE;
      data_q       <= 8'd0;
      bit_idx_q    <= 3'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      bit_idx_q    <= bit_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt0        = gnt0_c;
  assign gnt1        = gnt1_c;
  assign onebit_data = tx_bit;
  assign busy        = (state_q != IDLE) || gnt0_c || gnt1_c;
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4; follows
// UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_N = 11;
`else
  localparam int FRAME_N = 10;
`endif

  logic       clk;
  logic       rst;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       onebit_data;
  logic       busy;
  logic       last_grant;

  int checks;
  int failures;

  uart_tx_arbiter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .btn0        (rst),
    .req0        (req0),
    .data0       (data0),
    .req1        (req1),
    .data1       (data1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .onebit_data (onebit_data),
    .busy        (busy),
    .last_grant  (last_grant)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // Expected line level for frame bit i: start, 8 data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at negedge+1 of the cycle in which the grant is expected.
  task automatic expect_grant(input int idx);
    chk("gnt0", {7'd0, gnt0}, {7'd0, idx == 0});
    chk("gnt1", {7'd0, gnt1}, {7'd0, idx == 1});
    chk("busy_grant", {7'd0, busy}, 8'd1);
    chk("line_grant", {7'd0, onebit_data}, 8'd1);
  endtask

  // Walks every cycle of the frame; req_after/data change applied in its first cycle.
  task automatic run_frame(input logic [7:0] b, input int idx, input logic [1:0] req_after,
                           input logic chg, input logic [7:0] chg_val);
    for (int i = 0; i < FRAME_N; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) begin
          req0 = req_after[0];
          req1 = req_after[1];
          if (chg) data0 = chg_val;
        end
        #1;
        if (i == 0 && c == 0) chk("last_grant", {7'd0, last_grant}, idx[7:0]);
        chk($sformatf("line_b%0d_c%0d", i, c), {7'd0, onebit_data}, {7'd0, exp_bit(b, i)});
        chk("busy_frame", {7'd0, busy}, 8'd1);
        chk("gnt_in_frame", {6'd0, gnt1, gnt0}, 8'd0);
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    #1;
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_line", {7'd0, onebit_data}, 8'd1);
    chk("idle_gnt", {6'd0, gnt1, gnt0}, 8'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_line", {7'd0, onebit_data}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_gnt", {6'd0, gnt1, gnt0}, 8'd0);
    chk("rst_last", {7'd0, last_grant}, 8'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame A5: 0,1,0,1,0,0,1,0,1,1; busy 1 + 40 cycles, then low
    @(negedge clk);
    req0 = 1'b1; data0 = 8'hA5;
    #1;
    expect_grant(0);
    run_frame(8'hA5, 0, 2'b00, 1'b0, 8'h00);
    idle_check();

    // req0 alone again with last_grant=0; data0 changes after grant
    @(negedge clk);
    req0 = 1'b1; data0 = 8'h00;
    #1;
    expect_grant(0);
    run_frame(8'h00, 0, 2'b00, 1'b1, 8'hFF);
    idle_check();

    // Both requesting from reset: 11 then 22 with a one-cycle gap
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    #1;
    expect_grant(0);
    run_frame(8'h11, 0, 2'b10, 1'b0, 8'h00);
    @(negedge clk); #1;
    expect_grant(1);
    run_frame(8'h22, 1, 2'b00, 1'b0, 8'h00);
    idle_check();
    chk("last_after_pair", {7'd0, last_grant}, 8'd1);

    // req1 held, req0 toggled every frame: alternate under contention
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h5A; data1 = 8'hC3;
    #1;
    expect_grant(0);
    run_frame(8'h5A, 0, 2'b10, 1'b0, 8'h00);
    @(negedge clk); #1;
    expect_grant(1);
    run_frame(8'hC3, 1, 2'b11, 1'b0, 8'h00);
    @(negedge clk); #1;
    expect_grant(0);
    run_frame(8'h5A, 0, 2'b10, 1'b0, 8'h00);
    @(negedge clk); #1;
    expect_grant(1);
    run_frame(8'hC3, 1, 2'b00, 1'b0, 8'h00);
    idle_check();

    // 07: odd population, parity bit is 1 when enabled
    @(negedge clk);
    req1 = 1'b1; data1 = 8'h07;
    #1;
    expect_grant(1);
    run_frame(8'h07, 1, 2'b00, 1'b0, 8'h00);
    idle_check();

    // Reset during data bit 3 aborts the frame immediately
    @(negedge clk);
    req0 = 1'b1; data0 = 8'h30;
    #1;
    expect_grant(0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) req0 = 1'b0;
    end
    #1;
    chk("bit3_before_rst", {7'd0, onebit_data}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_line", {7'd0, onebit_data}, 8'd1);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_gnt", {6'd0, gnt1, gnt0}, 8'd0);
    chk("abort_last", {7'd0, last_grant}, 8'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk("post_abort_line", {7'd0, onebit_data}, 8'd1);
      chk("post_abort_busy", {7'd0, busy}, 8'd0);
    end
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h96; data1 = 8'h69;
    #1;
    expect_grant(0);
    run_frame(8'h96, 0, 2'b10, 1'b0, 8'h00);
    @(negedge clk); #1;
    expect_grant(1);
    run_frame(8'h69, 1, 2'b00, 1'b0, 8'h00);
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 btn0  input  1  reset; asynchronous, active-high.
REQ-004 req0  input  1  requester 0 has a byte to send; held high until gnt0.
REQ-005 data0  input  8  requester 0 byte; sampled in the gnt0 cycle.
REQ-006 req1  input  1  requester 1 has a byte to send; held high until gnt1.
REQ-007 data1  input  8  requester 1 byte; sampled in the gnt1 cycle.
REQ-008 gnt0  output  1  one-cycle pulse: data0 accepted.
REQ-009 gnt1  output  1  one-cycle pulse: data1 accepted.
REQ-010 onebit_data  output  1  shared serial line; idle high, LSB first.
REQ-011 busy  output  1  high from the grant cycle through the last stop-bit cycle.
REQ-012 last_grant  output  1  index of the most recently granted requester.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE with any req high, it SHALL pulse exactly one gnt, latch that byte, assert busy, and enter START on the next edge.
REQ-015 When req0 and req1 are both high, it SHALL grant the requester other than last_grant (round robin).
REQ-016 A single requester SHALL be granted regardless of last_grant.
REQ-017 gnt0 and gnt1 SHALL never be high in the same cycle and SHALL never be high outside IDLE.
REQ-018 START SHALL drive onebit_data low for exactly CLKS_PER_BIT cycles.
REQ-019 DATA SHALL drive the 8 latched bits LSB first, each for CLKS_PER_BIT cycles, with a 3-bit index that runs 0..7 and then exits.
REQ-020 STOP SHALL drive onebit_data high for CLKS_PER_BIT cycles, then return to IDLE with busy low.
REQ-021 A request pending at STOP exit SHALL be granted in the first IDLE cycle, so the inter-frame gap is exactly one clk cycle.
REQ-022 Changes on data0/data1 after the grant SHALL NOT affect the frame in flight.
REQ-023 The bit-period counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 on each bit boundary, and be held at 0 in IDLE.
REQ-024 Requests that drop before their grant SHALL be ignored without error.

Reset
REQ-025 btn0 high SHALL immediately force: state IDLE, onebit_data 1, busy 0, gnt0/gnt1 0, last_grant 1 (the first contended grant goes to req0), counters 0.
REQ-026 A reset mid-frame SHALL abort the frame with no further bits; after release the aborted requester is not considered granted.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, PARITY SHALL follow DATA and drive even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, for an 11-bit frame.
REQ-028 Without UART_TX_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and the frame SHALL be 10 bits.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum type, the CLKS_PER_BIT default, and the frame-length constants (10/11).
REQ-030 Sub-module uart_baud_counter SHALL generate the bit-boundary tick (enable in, tick out, CLKS_PER_BIT parameter); the arbiter SHALL contain the FSM, the round-robin pointer and the shift register.

Verification (sim with CLKS_PER_BIT=4, parity off unless stated)
REQ-031 req0=1, data0=8'hA5 -> one gnt0 pulse; line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; busy high for 41 cycles.
REQ-032 req0 and req1 both high from reset, data0=8'h11, data1=8'h22 -> frames 8'h11 then 8'h22; last_grant sequence 0,1; 1-cycle gap between the two frames.
REQ-033 req1 held high continuously with req0 toggled every frame -> grants alternate whenever both are high; no gnt while busy.
REQ-034 UART_TX_PARITY_EN defined, data0=8'h07 -> parity bit 1, frame 11 bits (44 cycles of line activity).
REQ-035 btn0 pulsed at data bit 3 of a frame -> onebit_data=1 and busy=0 in the same cycle; next request starts a clean frame with a start bit.
REQ-036 data0 changed to 8'hFF one cycle after gnt0 for 8'h00 -> all eight transmitted data bits are 0.
